// File: rtl/mux8way_rr_collector.sv
// mux8way_rr_collector
// Merges eight valid/ready source channels onto one registered output
// stream. A round-robin arbiter picks one requesting channel per cycle.
// Each output beat carries its 3-bit source index so a downstream
// distributor can route it back.
//
// Build option:
//   FIXED_PRIORITY_EN - when defined, the search always starts at channel 0
//                       and the lowest index wins. No rotating pointer is
//                       kept. When undefined (the default), round-robin is used.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel valid, bit i = channel i
//   in_data    packed channel data, channel i = in_data[i*WIDTH +: WIDTH]
//   in_ready   per-channel ready, at most one bit high
//   out_valid  output beat present
//   out_data   data of the held beat
//   out_sel    source channel of the held beat
//   out_ready  consumer accepts the held beat when high
module mux8way_rr_collector #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [2:0]       r_out_sel;

  logic [WIDTH-1:0] w_chan [8];
  logic [2:0]       w_start;
  logic             w_can_load;
  logic             w_found;
  logic [2:0]       w_gnt_idx;
  logic             w_grant;

  for (genvar gi = 0; gi < 8; gi++) begin : g_chan
    assign w_chan[gi] = in_data[gi*WIDTH +: WIDTH];
  end

`ifdef FIXED_PRIORITY_EN
  assign w_start = 3'd0;
`else
  logic [2:0] r_ptr;

  // The pointer only advances past a granted channel. A dropped request leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 3'd0;
    end else if (w_grant) begin
      r_ptr <= w_gnt_idx + 3'd1;
    end
  end

  assign w_start = r_ptr;
`endif

  // The output register refills on the same edge it drains.
  assign w_can_load = !r_out_valid || out_ready;

  // Search upward from w_start. The 3-bit add wraps 7 -> 0.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      logic [2:0] idx;
      idx = w_start + 3'(k);
      if (!w_found && in_valid[idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = idx;
      end
    end
  end

  // Gate with rst_n so no channel sees ready while the block is held in reset.
  assign w_grant  = rst_n && w_can_load && w_found;
  assign in_ready = w_grant ? (8'b0000_0001 << w_gnt_idx) : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 3'd0;
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_chan[w_gnt_idx];
      r_out_sel   <= w_gnt_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux8way_rr_collector.sv
module tb_mux8way_rr_collector;

  localparam int unsigned WIDTH = 16;

  logic               clk;
  logic               rst_n;
  logic [7:0]         in_valid;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_ready;

  int checks;
  int errors;
  logic [WIDTH-1:0] d [8];

  mux8way_rr_collector #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [2:0] sel);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sel"}, 32'(out_sel), 32'(sel));
    chk({tag, "_data"}, 32'(out_data), 32'(d[sel]));
  endtask

  function automatic logic [2:0] rr(input int k);
`ifdef FIXED_PRIORITY_EN
    return 3'd0;
`else
    return 3'(k % 8);
`endif
  endfunction

  initial begin
    logic [2:0] wrap_exp [3];
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) d[i] = 16'hA000 + 16'(i);
    d[2] = 16'hBEEF;
    for (int i = 0; i < 8; i++) in_data[i*WIDTH +: WIDTH] = d[i];

    // Reset with every channel requesting
    rst_n     = 1'b0;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'h00);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(in_ready), 32'h01);

    // All valid for 10 cycles
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_beat($sformatf("allv%0d", k), rr(k));
    end

    // Idle to drain the output; ptr is now 2 in round-robin
    in_valid = 8'h00;
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Single source on ch2
    in_valid = 8'b0000_0100;
    #1;
    chk("single_ready", 32'(in_ready), 32'h04);
    tick();
    in_valid = 8'h00;
    chk_beat("single", 3'd2);
    tick();
    chk("single_drain", 32'(out_valid), 32'd0);

    // Backpressure: a beat from ch5 stalls while ch6 waits
    in_valid = 8'b0110_0000;
    #1;
    chk("bp_ready5", 32'(in_ready), 32'h20);
    tick();
    out_ready = 1'b0;
    in_valid  = 8'b0100_0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_beat($sformatf("bp_hold%0d", k), 3'd5);
      chk($sformatf("bp_ready_hold%0d", k), 32'(in_ready), 32'h00);
      tick();
    end
    chk_beat("bp_hold_end", 3'd5);
    out_ready = 1'b1;
    #1;
    chk("bp_ready6", 32'(in_ready), 32'h40);
    tick();
    in_valid = 8'h00;
    chk_beat("bp_ch6", 3'd6);
    tick();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Wrap/skip with ptr at 7
`ifdef FIXED_PRIORITY_EN
    wrap_exp[0] = 3'd0; wrap_exp[1] = 3'd0; wrap_exp[2] = 3'd0;
`else
    wrap_exp[0] = 3'd0; wrap_exp[1] = 3'd3; wrap_exp[2] = 3'd0;
`endif
    in_valid = 8'b0000_1001;
    #1;
    chk("wrap_ready", 32'(in_ready), 32'h01);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_beat($sformatf("wrap%0d", k), wrap_exp[k]);
    end

    // Async reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_sel", 32'(out_sel), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    in_valid = 8'hFF;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_beat($sformatf("restart%0d", k), rr(k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
